// File: rtl/instruction_encoder_loader.sv
// Packs structured instruction fields into 16-bit ISA words and streams them
// into program memory over a valid/ready write port, one load session per start.
module instruction_encoder_loader #(
  parameter int unsigned ADDR_BITS    = 8,
  parameter bit          STOP_ON_HALT = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] start_address,
  input  logic                 finish,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [3:0]           opcode,
  input  logic [3:0]           Rd,
  input  logic [3:0]           Rs,
  input  logic [3:0]           Rt,
  input  logic [7:0]           IMM8,
  input  logic [3:0]           condition,
  output logic                 mem_write_valid,
  input  logic                 mem_write_ready,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [15:0]          mem_write_data,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic                 bad_opcode,
  output logic [ADDR_BITS:0]   words_written
);

  localparam int unsigned CNT_W = ADDR_BITS + 1;
  localparam logic [ADDR_BITS-1:0] ADDR_LAST = '1;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [15:0]          data_q, data_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 bad_q, bad_d;
  logic                 fin_q, fin_d;
  logic                 op_ready_q, op_ready_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [15:0] enc_word;
  logic        enc_legal;

  // Field packing; fields unused by an opcode are forced to zero.
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (opcode)
      4'h0:                   enc_word = 16'h0000;
      4'h1:                   enc_word = {opcode, condition, IMM8};
      4'h2, 4'h8:             enc_word = {opcode, 4'h0, Rs, Rt};
      4'h3, 4'h4, 4'h5, 4'h6: enc_word = {opcode, Rd, Rs, Rt};
      4'h7:                   enc_word = {opcode, Rd, Rs, 4'h0};
      4'h9:                   enc_word = {opcode, Rd, IMM8};
      OP_HALT:                enc_word = 16'hF000;
      default:                enc_legal = 1'b0;
    endcase
  end

  // Next-state logic; outputs are registered from the next state.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    bad_d      = bad_q;
    fin_d      = fin_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_ACCEPT;
          addr_d     = start_address;
          count_d    = '0;
          overflow_d = 1'b0;
          bad_d      = 1'b0;
          fin_d      = 1'b0;
        end
      end
      S_ACCEPT: begin
        if (finish) begin
          state_d = S_DONE;
        end else if (op_valid) begin
          if (enc_legal) begin
            data_d  = enc_word;
            fin_d   = 1'b0;
            state_d = S_WRITE;
          end else begin
            bad_d = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (finish) fin_d = 1'b1;
        if (mem_write_ready) begin
          count_d = count_q + CNT_W'(1);
          if (STOP_ON_HALT && (data_q[15:12] == OP_HALT)) begin
            state_d = S_DONE;
          end else if (addr_q == ADDR_LAST) begin
            overflow_d = 1'b1;
            state_d    = S_DONE;
          end else if (fin_q || finish) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + ADDR_BITS'(1);
            state_d = S_ACCEPT;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    op_ready_d = (state_d == S_ACCEPT);
    valid_d    = (state_d == S_WRITE);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      bad_q      <= 1'b0;
      fin_q      <= 1'b0;
      op_ready_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      bad_q      <= bad_d;
      fin_q      <= fin_d;
      op_ready_q <= op_ready_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign op_ready          = op_ready_q;
  assign mem_write_valid   = valid_q;
  assign mem_write_address = addr_q;
  assign mem_write_data    = data_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign overflow          = overflow_q;
  assign bad_opcode        = bad_q;
  assign words_written     = count_q;

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Directed bench for instruction_encoder_loader: encodings, addressing,
// illegal opcodes, overflow, write stalls with finish, and reset mid-write.
module tb_instruction_encoder_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] start_address;
  logic       finish;
  logic       op_valid;
  logic       op_ready;
  logic [3:0] opcode, Rd, Rs, Rt, condition;
  logic [7:0] IMM8;
  logic       mem_write_valid;
  logic       mem_write_ready;
  logic [7:0] mem_write_address;
  logic [15:0] mem_write_data;
  logic       busy, done, overflow, bad_opcode;
  logic [8:0] words_written;

  int tests = 0;
  int fails = 0;

  instruction_encoder_loader #(.ADDR_BITS(8), .STOP_ON_HALT(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .start_address(start_address),
    .finish(finish), .op_valid(op_valid), .op_ready(op_ready), .opcode(opcode),
    .Rd(Rd), .Rs(Rs), .Rt(Rt), .IMM8(IMM8), .condition(condition),
    .mem_write_valid(mem_write_valid), .mem_write_ready(mem_write_ready),
    .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
    .busy(busy), .done(done), .overflow(overflow), .bad_opcode(bad_opcode),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] a);
    start = 1'b1; start_address = a;
    tick();
    start = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] d, input logic [3:0] s,
                       input logic [3:0] t, input logic [7:0] imm, input logic [3:0] c);
    op_valid = 1'b1; opcode = op; Rd = d; Rs = s; Rt = t; IMM8 = imm; condition = c;
    tick();
    op_valid = 1'b0; opcode = 4'h0; Rd = 4'h0; Rs = 4'h0; Rt = 4'h0; IMM8 = 8'h00; condition = 4'h0;
  endtask

  task automatic handshake();
    mem_write_ready = 1'b1;
    tick();
    mem_write_ready = 1'b0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1;
    tick();
    finish = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tests++;
    if ({op_ready, mem_write_valid, busy, done, overflow, bad_opcode} !== 6'b0 ||
        mem_write_address !== 8'h00 || mem_write_data !== 16'h0000 || words_written !== 9'd0) begin
      fails++;
      $display("FAIL reset_outputs got rdy=%b v=%b busy=%b done=%b a=%h d=%h w=%0d exp all zero",
               op_ready, mem_write_valid, busy, done, mem_write_address, mem_write_data, words_written);
    end
  endtask

  task automatic test_basic_session();
    do_start(8'h10);
    tests++;
    if (op_ready !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL t1_accept got rdy=%b busy=%b exp 1 1", op_ready, busy);
    end
    issue(4'h3, 4'h1, 4'h2, 4'h3, 8'h00, 4'h0);
    tests++;
    if (mem_write_valid !== 1'b1 || mem_write_address !== 8'h10 || mem_write_data !== 16'h3123 || op_ready !== 1'b0) begin
      fails++; $display("FAIL t1_add got v=%b a=%h d=%h rdy=%b exp 1 10 3123 0",
                        mem_write_valid, mem_write_address, mem_write_data, op_ready);
    end
    handshake();
    issue(4'h9, 4'h4, 4'h0, 4'h0, 8'hAB, 4'h0);
    tests++;
    if (mem_write_valid !== 1'b1 || mem_write_address !== 8'h11 || mem_write_data !== 16'h94AB) begin
      fails++; $display("FAIL t1_const got v=%b a=%h d=%h exp 1 11 94ab", mem_write_valid, mem_write_address, mem_write_data);
    end
    handshake();
    issue(4'hF, 4'h5, 4'h6, 4'h7, 8'h12, 4'h3);
    tests++;
    if (mem_write_address !== 8'h12 || mem_write_data !== 16'hF000) begin
      fails++; $display("FAIL t1_halt got a=%h d=%h exp 12 f000", mem_write_address, mem_write_data);
    end
    handshake();
    tests++;
    if (done !== 1'b1 || words_written !== 9'd3 || mem_write_valid !== 1'b0) begin
      fails++; $display("FAIL t1_done got done=%b w=%0d v=%b exp 1 3 0", done, words_written, mem_write_valid);
    end
    tick();
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || words_written !== 9'd3) begin
      fails++; $display("FAIL t1_idle got done=%b busy=%b w=%0d exp 0 0 3", done, busy, words_written);
    end
  endtask

  task automatic test_encodings();
    do_start(8'h20);
    issue(4'h8, 4'h7, 4'h2, 4'h5, 8'hFF, 4'hF);
    tests++;
    if (mem_write_data !== 16'h8025 || mem_write_address !== 8'h20) begin
      fails++; $display("FAIL t2_str got a=%h d=%h exp 20 8025", mem_write_address, mem_write_data);
    end
    handshake();
    issue(4'h7, 4'h1, 4'h2, 4'h9, 8'hFF, 4'hF);
    tests++;
    if (mem_write_data !== 16'h7120 || mem_write_address !== 8'h21) begin
      fails++; $display("FAIL t2_ldr got a=%h d=%h exp 21 7120", mem_write_address, mem_write_data);
    end
    handshake();
    issue(4'h0, 4'hF, 4'hF, 4'hF, 8'hFF, 4'hF);
    tests++;
    if (mem_write_valid !== 1'b1 || mem_write_data !== 16'h0000 || mem_write_address !== 8'h22) begin
      fails++; $display("FAIL t2_nop got v=%b a=%h d=%h exp 1 22 0000", mem_write_valid, mem_write_address, mem_write_data);
    end
    handshake();
    issue(4'h1, 4'hF, 4'hF, 4'hF, 8'h5A, 4'h6);
    tests++;
    if (mem_write_data !== 16'h165A || mem_write_address !== 8'h23) begin
      fails++; $display("FAIL t2_br got a=%h d=%h exp 23 165a", mem_write_address, mem_write_data);
    end
    handshake();
    pulse_finish();
    tests++;
    if (done !== 1'b1 || words_written !== 9'd4) begin
      fails++; $display("FAIL t2_finish got done=%b w=%0d exp 1 4", done, words_written);
    end
    tick();
  endtask

  task automatic test_bad_opcode();
    do_start(8'h30);
    issue(4'hC, 4'h1, 4'h2, 4'h3, 8'h44, 4'h5);
    tests++;
    if (bad_opcode !== 1'b1 || mem_write_valid !== 1'b0 || op_ready !== 1'b1 || mem_write_address !== 8'h30) begin
      fails++; $display("FAIL t3_bad got bad=%b v=%b rdy=%b a=%h exp 1 0 1 30",
                        bad_opcode, mem_write_valid, op_ready, mem_write_address);
    end
    issue(4'h2, 4'hF, 4'h1, 4'h2, 8'hFF, 4'hF);
    tests++;
    if (mem_write_valid !== 1'b1 || mem_write_data !== 16'h2012 || mem_write_address !== 8'h30) begin
      fails++; $display("FAIL t3_cmp got v=%b a=%h d=%h exp 1 30 2012", mem_write_valid, mem_write_address, mem_write_data);
    end
    handshake();
    pulse_finish();
    tick();
    tests++;
    if (bad_opcode !== 1'b1 || words_written !== 9'd1 || busy !== 1'b0) begin
      fails++; $display("FAIL t3_sticky got bad=%b w=%0d busy=%b exp 1 1 0", bad_opcode, words_written, busy);
    end
  endtask

  task automatic test_overflow();
    do_start(8'hFE);
    tests++;
    if (bad_opcode !== 1'b0 || words_written !== 9'd0) begin
      fails++; $display("FAIL t4_clear got bad=%b w=%0d exp 0 0", bad_opcode, words_written);
    end
    issue(4'h3, 4'h1, 4'h1, 4'h1, 8'h00, 4'h0);
    tests++;
    if (mem_write_address !== 8'hFE || mem_write_data !== 16'h3111) begin
      fails++; $display("FAIL t4_fe got a=%h d=%h exp fe 3111", mem_write_address, mem_write_data);
    end
    handshake();
    issue(4'h4, 4'h2, 4'h3, 4'h4, 8'h00, 4'h0);
    tests++;
    if (mem_write_address !== 8'hFF || mem_write_data !== 16'h4234) begin
      fails++; $display("FAIL t4_ff got a=%h d=%h exp ff 4234", mem_write_address, mem_write_data);
    end
    handshake();
    tests++;
    if (done !== 1'b1 || overflow !== 1'b1 || words_written !== 9'd2 || mem_write_valid !== 1'b0 || op_ready !== 1'b0) begin
      fails++; $display("FAIL t4_ovf got done=%b ovf=%b w=%0d v=%b rdy=%b exp 1 1 2 0 0",
                        done, overflow, words_written, mem_write_valid, op_ready);
    end
    tick();
    tests++;
    if (mem_write_valid !== 1'b0 || overflow !== 1'b1 || busy !== 1'b0 || mem_write_address === 8'h00) begin
      fails++; $display("FAIL t4_nowrap got v=%b ovf=%b busy=%b a=%h exp 0 1 0 ff",
                        mem_write_valid, overflow, busy, mem_write_address);
    end
  endtask

  task automatic test_stall_finish();
    do_start(8'h40);
    tests++;
    if (overflow !== 1'b0) begin
      fails++; $display("FAIL t5_ovf_clear got %b exp 0", overflow);
    end
    issue(4'h5, 4'h5, 4'h6, 4'h7, 8'h00, 4'h0);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (mem_write_valid !== 1'b1 || mem_write_address !== 8'h40 || mem_write_data !== 16'h5567 || op_ready !== 1'b0) begin
        fails++; $display("FAIL t5_stall%0d got v=%b a=%h d=%h rdy=%b exp 1 40 5567 0",
                          i, mem_write_valid, mem_write_address, mem_write_data, op_ready);
      end
      if (i == 1) pulse_finish();
      else tick();
    end
    handshake();
    tests++;
    if (done !== 1'b1 || words_written !== 9'd1 || op_ready !== 1'b0) begin
      fails++; $display("FAIL t5_done got done=%b w=%0d rdy=%b exp 1 1 0", done, words_written, op_ready);
    end
    tick();
  endtask

  task automatic test_reset_mid_write();
    do_start(8'h50);
    issue(4'h6, 4'h1, 4'h2, 4'h3, 8'h00, 4'h0);
    do_start(8'h77);
    tests++;
    if (mem_write_valid !== 1'b1 || mem_write_address !== 8'h50 || mem_write_data !== 16'h6123) begin
      fails++; $display("FAIL t6_start_ign got v=%b a=%h d=%h exp 1 50 6123", mem_write_valid, mem_write_address, mem_write_data);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if ({op_ready, mem_write_valid, busy, done, overflow, bad_opcode} !== 6'b0 ||
        mem_write_address !== 8'h00 || mem_write_data !== 16'h0000 || words_written !== 9'd0) begin
      fails++; $display("FAIL t6_reset got rdy=%b v=%b busy=%b done=%b a=%h d=%h w=%0d exp all zero",
                        op_ready, mem_write_valid, busy, done, mem_write_address, mem_write_data, words_written);
    end
    tick();
    tests++;
    if (busy !== 1'b0 || mem_write_valid !== 1'b0) begin
      fails++; $display("FAIL t6_idle got busy=%b v=%b exp 0 0", busy, mem_write_valid);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start_address = 8'h00; finish = 1'b0;
    op_valid = 1'b0; opcode = 4'h0; Rd = 4'h0; Rs = 4'h0; Rt = 4'h0;
    IMM8 = 8'h00; condition = 4'h0; mem_write_ready = 1'b0;
    test_reset();
    test_basic_session();
    test_encodings();
    test_bad_opcode();
    test_overflow();
    test_stall_finish();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
